// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller: opcode encoding, FSM states and opcode legality check.
// Latency: none (declarations only).
// Backpressure: n/a.
package alu_issue_ctrl_pkg;

    localparam int ALU_OPW = 4;

    typedef enum logic [ALU_OPW-1:0] {
        OP_XOR = 4'd3,
        OP_ADD = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_AND = 4'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } issue_state_t;

    function automatic logic is_legal_op(input logic [ALU_OPW-1:0] op);
        case (op)
            OP_XOR, OP_ADD, OP_SHL, OP_SHR, OP_AND: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first set request at or after ptr+1 (mod NREQ).
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
// Ports: req_i (request vector), ptr_i (last winner), grant_o (one-hot grant, zero if no request).
module alu_issue_ctrl_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o
);

    logic          found;
    int            idx_int;
    logic [PW-1:0] idx;

    // Walk the requesters in rotating priority order; the first hit wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx_int = 0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_int = (int'(ptr_i) + k) % NREQ;
            idx     = idx_int[PW-1:0];
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one external combinational ALU among NREQ requesters, one op in flight at a time.
// Latency: accept at edge N -> rsp_valid_o from cycle N+2; at least 3 cycles per op.
// Backpressure: holds the response until the owner's rsp_ready_i; accepts nothing while busy_o.
// Ports: req_* valid/ready request channel (flattened op/A/B), rsp_* valid/ready response channel,
//        alu_op_o/alu_a_o/alu_b_o/alu_out_i to the external ALU, busy_o = not idle.
// Optional: define ALU_ZERO_FLAG_EN to add rsp_zero_o (result-is-zero flag, 0 on illegal op).
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*OPW-1:0]   req_op_i,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*WIDTH-1:0] req_b_i,
    output logic [NREQ-1:0]       rsp_valid_o,
    input  logic [NREQ-1:0]       rsp_ready_i,
    output logic [WIDTH-1:0]      rsp_data_o,
    output logic                  rsp_err_o,
`ifdef ALU_ZERO_FLAG_EN
    output logic                  rsp_zero_o,
`endif
    output logic [OPW-1:0]        alu_op_o,
    output logic [WIDTH-1:0]      alu_a_o,
    output logic [WIDTH-1:0]      alu_b_o,
    input  logic [WIDTH-1:0]      alu_out_i,
    output logic                  busy_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    issue_state_t     state_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    owner_q;
    logic [PW-1:0]    owner_d;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic [NREQ-1:0]  rsp_valid_q;
    logic [NREQ-1:0]  grant;
    logic             op_legal;
`ifdef ALU_ZERO_FLAG_EN
    logic             rsp_zero_q;
`endif

    alu_issue_ctrl_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // Binary index of the one-hot grant.
    always_comb begin
        owner_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) owner_d = PW'(i);
        end
    end

    assign op_legal = is_legal_op(op_q);

    // Grants are only offered in IDLE, and never while reset is held.
    assign req_ready_o = (state_q == IDLE && !rst_i) ? grant : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= PW'(NREQ - 1);
            owner_q     <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= '0;
`ifdef ALU_ZERO_FLAG_EN
            rsp_zero_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        op_q    <= req_op_i[owner_d*OPW +: OPW];
                        a_q     <= req_a_i[owner_d*WIDTH +: WIDTH];
                        b_q     <= req_b_i[owner_d*WIDTH +: WIDTH];
                        owner_q <= owner_d;
                        ptr_q   <= owner_d;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Illegal opcodes still take the ISSUE slot but the ALU result is discarded.
                    if (op_legal) begin
                        rsp_data_q <= alu_out_i;
                        rsp_err_q  <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
                        rsp_zero_q <= (alu_out_i == '0);
`endif
                    end else begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
`ifdef ALU_ZERO_FLAG_EN
                        rsp_zero_q <= 1'b0;
`endif
                    end
                    rsp_valid_q <= NREQ'(1) << owner_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i[owner_q]) begin
                        rsp_valid_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= '0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
`ifdef ALU_ZERO_FLAG_EN
    assign rsp_zero_o  = rsp_zero_q;
`endif
    assign alu_op_o    = op_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the ALU port.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_err;
`ifdef ALU_ZERO_FLAG_EN
    logic        rsp_zero;
`endif
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl #(.NREQ(2), .WIDTH(8), .OPW(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
`ifdef ALU_ZERO_FLAG_EN
        .rsp_zero_o  (rsp_zero),
`endif
        .alu_op_o    (alu_op),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_out_i   (alu_out),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU; unknown opcodes produce a non-zero pattern so a leaked result is visible.
    always_comb begin
        case (alu_op)
            4'd3:    alu_out = alu_a ^ alu_b;
            4'd4:    alu_out = alu_a + alu_b;
            4'd5:    alu_out = alu_a << alu_b[2:0];
            4'd6:    alu_out = alu_a >> alu_b[2:0];
            4'd7:    alu_out = alu_a & alu_b;
            default: alu_out = 8'hA5;
        endcase
    end

    task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[i*4 +: 4] = op;
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
    endtask

    // Leaves the bench at a falling edge with reset released.
    task automatic do_reset();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns just after a falling edge at which some grant is offered.
    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_op = '0; req_a = '0; req_b = '0;
        #1 rst = 1'b1;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid_busy: got %b/%b expected 00/0", rsp_valid, busy); end
        checks++; if (rsp_data !== 8'h00 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_data_err: got %h/%b expected 00/0", rsp_data, rsp_err); end
        checks++; if ({alu_op, alu_a, alu_b} !== 20'h0) begin errors++; $display("FAIL reset_alu: got %h expected 00000", {alu_op, alu_a, alu_b}); end
        do_reset();
    endtask

    task automatic test_single_op();
        bit ok;
        do_reset();
        set_req(0, 4'd4, 8'h0F, 8'h01);
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        wait_grant(ok);
        checks++; if (!ok || req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || rsp_valid !== 2'b00) begin errors++; $display("FAIL single_issue: got busy %b valid %b expected 1/00", busy, rsp_valid); end
        checks++; if ({alu_op, alu_a, alu_b} !== {4'd4, 8'h0F, 8'h01}) begin errors++; $display("FAIL single_alu_drive: got %h expected 40f01", {alu_op, alu_a, alu_b}); end
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h10 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp: got %b/%h/%b expected 01/10/0", rsp_valid, rsp_data, rsp_err); end
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got %b/%b expected 00/0", rsp_valid, busy); end
    endtask

    task automatic test_contention();
        bit ok;
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0] exp_d [4] = '{8'hFF, 8'h30, 8'hFF, 8'h30};
        do_reset();
        set_req(0, 4'd3, 8'hAA, 8'h55);
        set_req(1, 4'd7, 8'hF0, 8'h3C);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_grant(ok);
            checks++; if (!ok || req_ready !== exp_g[n]) begin errors++; $display("FAIL contention_grant%0d: got %b expected %b", n, req_ready, exp_g[n]); end
            @(negedge clk);
            @(negedge clk);
            checks++; if (rsp_valid !== exp_g[n] || rsp_data !== exp_d[n]) begin errors++; $display("FAIL contention_rsp%0d: got %b/%h expected %b/%h", n, rsp_valid, rsp_data, exp_g[n], exp_d[n]); end
            @(negedge clk);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        set_req(1, 4'd5, 8'h01, 8'h03);
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        wait_grant(ok);
        checks++; if (!ok || req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant: got %b expected 10", req_ready); end
        @(posedge clk); #1;
        set_req(0, 4'd4, 8'h01, 8'h01);
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 2'b10 || rsp_data !== 8'h08 || req_ready !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got %b/%h/%b/%b expected 10/08/00/1", c, rsp_valid, rsp_data, req_ready, busy); end
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b01) begin errors++; $display("FAIL bp_release: got %b/%b expected 00/01", rsp_valid, req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_illegal_op();
        bit ok;
        do_reset();
        set_req(0, 4'h0, 8'h12, 8'h34);
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        wait_grant(ok);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        checks++; if (!ok || busy !== 1'b1 || alu_op !== 4'h0 || alu_a !== 8'h12) begin errors++; $display("FAIL illegal_issue: got %b/%h/%h expected 1/0/12", busy, alu_op, alu_a); end
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h00 || rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_rsp: got %b/%h/%b expected 01/00/1", rsp_valid, rsp_data, rsp_err); end
        set_req(1, 4'd4, 8'h01, 8'h02);
        req_valid = 2'b10;
        wait_grant(ok);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++; if (!ok || rsp_valid !== 2'b10 || rsp_data !== 8'h03 || rsp_err !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %b/%h/%b expected 10/03/0", rsp_valid, rsp_data, rsp_err); end
    endtask

    task automatic test_reset_midop();
        bit ok;
        do_reset();
        set_req(0, 4'd4, 8'h05, 8'h06);
        set_req(1, 4'd3, 8'h0F, 8'hF0);
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        wait_grant(ok);
        @(posedge clk); #1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (!ok || rsp_data !== 8'h0B) begin errors++; $display("FAIL midop_first: got %h expected 0b", rsp_data); end
        wait_grant(ok);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        checks++; if (!ok || busy !== 1'b1) begin errors++; $display("FAIL midop_in_issue: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if ({rsp_valid, rsp_data, rsp_err, req_ready, busy} !== 14'h0 || {alu_op, alu_a, alu_b} !== 20'h0) begin errors++; $display("FAIL midop_reset_outputs: got %h/%h expected 0/0", {rsp_valid, rsp_data, rsp_err, req_ready, busy}, {alu_op, alu_a, alu_b}); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL midop_no_rsp%0d: got %b/%b expected 00/0", c, rsp_valid, busy); end
        end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midop_first_grant: got %b expected 01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h0B) begin errors++; $display("FAIL midop_post_rsp: got %b/%h expected 01/0b", rsp_valid, rsp_data); end
        @(negedge clk);
    endtask

`ifdef ALU_ZERO_FLAG_EN
    task automatic test_zero_flag();
        bit ok;
        do_reset();
        checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL zero_reset: got %b expected 0", rsp_zero); end
        set_req(0, 4'd4, 8'hFF, 8'h01);
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        wait_grant(ok);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++; if (!ok || rsp_data !== 8'h00 || rsp_zero !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL zero_add: got %h/%b/%b expected 00/1/0", rsp_data, rsp_zero, rsp_err); end
        set_req(0, 4'h9, 8'h00, 8'h00);
        req_valid = 2'b01;
        wait_grant(ok);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++; if (!ok || rsp_zero !== 1'b0 || rsp_err !== 1'b1) begin errors++; $display("FAIL zero_illegal: got %b/%b expected 0/1", rsp_zero, rsp_err); end
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_illegal_op();
        test_reset_midop();
`ifdef ALU_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
